// File: rtl/wbm_bridge_pkg.sv
// Shared types and Wishbone field widths for the wbm_bridge request/response bridge.
package wbm_bridge_pkg;

    localparam int ADR_W = 28;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle watchdog for wbm_bridge: counts enabled cycles and flags the last allowed one.
module wbm_timeout_ctr #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stale count cannot wrap while the bridge sits idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/wbm_bridge.sv
// Single-outstanding pipelined Wishbone master bridge for a CPU-side request port.
// Optional bus watchdog enabled by defining WBM_BRIDGE_TIMEOUT_EN.
module wbm_bridge
    import wbm_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADR_W-1:0] req_adr,
    input  logic [DAT_W-1:0] req_dat,
    input  logic [SEL_W-1:0] req_sel,
    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    output logic             wbm_we_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic             wbm_stall_i
);

    state_t state, state_next;
    logic   accept;
    logic   done;
    logic   timeout;
    logic   hit;

    assign hit = wbm_ack_i | wbm_err_i;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (hit || timeout) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (!wbm_stall_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (hit || timeout) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding ready low during the response pulse keeps one idle cycle between transactions.
    assign req_ready = (state == IDLE) && !rsp_valid;
    assign wbm_cyc_o = (state != IDLE);
    assign wbm_stb_o = (state == REQ);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (accept) begin
                wbm_adr_o <= req_adr;
                wbm_dat_o <= req_dat;
                wbm_sel_o <= req_sel;
                wbm_we_o  <= req_we;
            end
            // A completion without ack can only be an error or a watchdog expiry.
            if (done) begin
                rsp_err <= wbm_err_i | ~wbm_ack_i;
                if (wbm_ack_i && !wbm_err_i && !wbm_we_o) begin
                    rsp_dat <= wbm_dat_i;
                end
            end
        end
    end

`ifdef WBM_BRIDGE_TIMEOUT_EN
    wbm_timeout_ctr #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (sys_clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (wbm_cyc_o),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wbm_bridge.sv
// Self-checking bench for wbm_bridge: directed scenarios plus randomized transactions
// checked against a transaction-level expectation model.
module tb_wbm_bridge;

    localparam int TO = 16;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [27:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [27:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic        wbm_stall_i = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_rsp_dat = '0;

    typedef struct {
        int          stb_cnt;
        int          stb_first;
        int          cyc_cnt;
        int          rv_cnt;
        int          rv_k;
        int          ready_k;
        bit          fields_ok;
        bit          stb_wo_cyc;
        logic [31:0] dat;
        logic        err;
    } obs_t;

    wbm_bridge #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_adr     (req_adr),
        .req_dat     (req_dat),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i),
        .wbm_stall_i (wbm_stall_i)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Issues one request and plays the slave: stall for stall_n stb cycles, then complete
    // at cycle end_k (cycles counted from the first stb cycle). Records what the bus showed.
    task automatic run_txn(input logic we, input logic [27:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int stall_n, input int end_k,
                           input bit give_ack, input bit give_err, input logic [31:0] rdata,
                           input int poke_k, input int run_len, output obs_t o);
        o.stb_cnt    = 0;
        o.stb_first  = -1;
        o.cyc_cnt    = 0;
        o.rv_cnt     = 0;
        o.rv_k       = -1;
        o.ready_k    = -1;
        o.fields_ok  = 1'b1;
        o.stb_wo_cyc = 1'b0;
        o.dat        = 'x;
        o.err        = 1'bx;
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        req_sel   = sel;
        step();
        req_valid = 1'b0;
        req_we    = ~we;
        req_adr   = 28'($urandom);
        req_dat   = $urandom;
        req_sel   = 4'($urandom);
        for (int k = 0; k < run_len; k++) begin
            if (wbm_stb_o) begin
                o.stb_cnt++;
                if (o.stb_first < 0) o.stb_first = k;
                if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel || wbm_we_o !== we)
                    o.fields_ok = 1'b0;
                if (wbm_cyc_o !== 1'b1) o.stb_wo_cyc = 1'b1;
            end
            if (wbm_cyc_o) o.cyc_cnt++;
            if (rsp_valid) begin
                o.rv_cnt++;
                o.rv_k = k;
                o.dat  = rsp_dat;
                o.err  = rsp_err;
            end
            if (req_ready && o.ready_k < 0) o.ready_k = k;
            req_valid   = (k == poke_k);
            wbm_stall_i = (k < stall_n);
            wbm_ack_i   = give_ack && (k == end_k);
            wbm_err_i   = give_err && (k == end_k);
            wbm_dat_i   = (k == end_k) ? rdata : $urandom;
            step();
        end
        req_valid   = 1'b0;
        wbm_stall_i = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_rsp_dat = '0;
        step();
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_cyc_stb_we: got %b expected 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        n_checks++;
        if ({wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_fields: got adr %h dat %h sel %h expected zeros", wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_dat} !== 34'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_rsp: got valid %b err %b dat %h expected zeros", rsp_valid, rsp_err, rsp_dat);
        end
    endtask

    task automatic test_write_no_stall();
        obs_t o;
        run_txn(1'b1, 28'h0000100, 32'hDEADBEEF, 4'hF, 0, 1, 1'b1, 1'b0, 32'hA5A5A5A5, -1, 4, o);
        n_checks++;
        if (o.stb_cnt !== 1 || o.stb_first !== 0) begin
            n_fail++;
            $display("[TB] FAIL write_stb: got %0d cycles first %0d expected 1 first 0", o.stb_cnt, o.stb_first);
        end
        n_checks++;
        if (!o.fields_ok) begin
            n_fail++;
            $display("[TB] FAIL write_fields: got mismatched bus fields expected adr 0000100 dat DEADBEEF sel F we 1");
        end
        n_checks++;
        if (o.rv_cnt !== 1 || o.rv_k !== 2) begin
            n_fail++;
            $display("[TB] FAIL write_rsp_valid: got %0d pulses at %0d expected 1 at 2", o.rv_cnt, o.rv_k);
        end
        n_checks++;
        if (o.err !== 1'b0 || o.dat !== model_rsp_dat) begin
            n_fail++;
            $display("[TB] FAIL write_rsp: got err %b dat %h expected err 0 dat %h", o.err, o.dat, model_rsp_dat);
        end
    endtask

    task automatic test_read_stall();
        obs_t o;
        run_txn(1'b0, 28'h0000200, 32'h0, 4'hF, 3, 5, 1'b1, 1'b0, 32'h12345678, -1, 8, o);
        model_rsp_dat = 32'h12345678;
        n_checks++;
        if (o.stb_cnt !== 4 || !o.fields_ok) begin
            n_fail++;
            $display("[TB] FAIL read_stall_stb: got %0d cycles stable %b expected 4 stable 1", o.stb_cnt, o.fields_ok);
        end
        n_checks++;
        if (o.cyc_cnt !== 6 || o.rv_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL read_stall_cyc: got cyc %0d rsp %0d expected cyc 6 rsp 1", o.cyc_cnt, o.rv_cnt);
        end
        n_checks++;
        if (o.dat !== model_rsp_dat || o.err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_stall_data: got %h err %b expected %h err 0", o.dat, o.err, model_rsp_dat);
        end
    endtask

    task automatic test_err_priority();
        obs_t o;
        run_txn(1'b0, 28'h0000300, 32'h0, 4'h3, 0, 1, 1'b1, 1'b1, 32'hCAFEF00D, -1, 4, o);
        n_checks++;
        if (o.rv_cnt !== 1 || o.err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_priority_err: got %0d pulses err %b expected 1 pulse err 1", o.rv_cnt, o.err);
        end
        n_checks++;
        if (o.dat !== model_rsp_dat) begin
            n_fail++;
            $display("[TB] FAIL err_priority_data: got %h expected %h", o.dat, model_rsp_dat);
        end
    endtask

    task automatic test_busy_request();
        obs_t        o;
        logic [31:0] rd = $urandom;
        run_txn(1'b0, 28'h0000400, 32'h0, 4'hF, 1, 4, 1'b1, 1'b0, rd, 2, 10, o);
        model_rsp_dat = rd;
        n_checks++;
        if (o.stb_cnt !== 2 || o.cyc_cnt !== 5) begin
            n_fail++;
            $display("[TB] FAIL busy_single_txn: got stb %0d cyc %0d expected stb 2 cyc 5", o.stb_cnt, o.cyc_cnt);
        end
        n_checks++;
        if (o.rv_cnt !== 1 || o.ready_k !== 6) begin
            n_fail++;
            $display("[TB] FAIL busy_rsp_ready: got rsp %0d ready at %0d expected rsp 1 ready at 6", o.rv_cnt, o.ready_k);
        end
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'b1;
            wbm_err_i = i[0];
            wbm_dat_i = $urandom;
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL idle_ack: got rsp_valid %b cyc %b ready %b expected 0 0 1", rsp_valid, wbm_cyc_o, req_ready);
            end
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        n_checks++;
        if (rsp_dat !== model_rsp_dat) begin
            n_fail++;
            $display("[TB] FAIL idle_ack_data: got %h expected %h", rsp_dat, model_rsp_dat);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            obs_t        o;
            logic        we    = 1'($urandom);
            logic [27:0] adr   = 28'($urandom);
            logic [31:0] dat   = $urandom;
            logic [3:0]  sel   = 4'($urandom);
            logic [31:0] rd    = $urandom;
            int          stall = $urandom_range(0, 4);
            int          delay = $urandom_range(0, 4);
            int          mode  = $urandom_range(0, 3);
            bit          ack   = (mode != 2);
            bit          err   = (mode >= 2);
            int          end_k = stall + delay;
            run_txn(we, adr, dat, sel, stall, end_k, ack, err, rd, -1, end_k + 3, o);
            if (ack && !err && !we) model_rsp_dat = rd;
            n_checks++;
            if (o.stb_cnt !== stall + 1 || o.stb_first !== 0 || !o.fields_ok || o.stb_wo_cyc) begin
                n_fail++;
                $display("[TB] FAIL rand_stb[%0d]: got %0d cycles first %0d ok %b expected %0d first 0 ok 1",
                         t, o.stb_cnt, o.stb_first, o.fields_ok && !o.stb_wo_cyc, stall + 1);
            end
            n_checks++;
            if (o.cyc_cnt !== end_k + 1 || o.rv_cnt !== 1 || o.rv_k !== end_k + 1 || o.ready_k !== end_k + 2) begin
                n_fail++;
                $display("[TB] FAIL rand_timing[%0d]: got cyc %0d rsp %0d@%0d ready@%0d expected cyc %0d rsp 1@%0d ready@%0d",
                         t, o.cyc_cnt, o.rv_cnt, o.rv_k, o.ready_k, end_k + 1, end_k + 1, end_k + 2);
            end
            n_checks++;
            if (o.err !== err || o.dat !== model_rsp_dat || rsp_dat !== model_rsp_dat) begin
                n_fail++;
                $display("[TB] FAIL rand_rsp[%0d]: got err %b dat %h held %h expected err %b dat %h",
                         t, o.err, o.dat, rsp_dat, err, model_rsp_dat);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
`ifdef WBM_BRIDGE_TIMEOUT_EN
        logic [31:0] rd = $urandom;
        run_txn(1'b0, 28'h0000500, 32'h0, 4'hF, 0, TO - 1, 1'b0, 1'b0, 32'h0, -1, TO + 3, o);
        n_checks++;
        if (o.cyc_cnt !== TO || o.rv_cnt !== 1 || o.rv_k !== TO) begin
            n_fail++;
            $display("[TB] FAIL timeout_timing: got cyc %0d rsp %0d@%0d expected cyc %0d rsp 1@%0d",
                     o.cyc_cnt, o.rv_cnt, o.rv_k, TO, TO);
        end
        n_checks++;
        if (o.err !== 1'b1 || o.dat !== model_rsp_dat) begin
            n_fail++;
            $display("[TB] FAIL timeout_rsp: got err %b dat %h expected err 1 dat %h", o.err, o.dat, model_rsp_dat);
        end
        run_txn(1'b0, 28'h0000600, 32'h0, 4'hF, 0, TO - 1, 1'b1, 1'b0, rd, -1, TO + 3, o);
        model_rsp_dat = rd;
        n_checks++;
        if (o.rv_cnt !== 1 || o.err !== 1'b0 || o.dat !== model_rsp_dat) begin
            n_fail++;
            $display("[TB] FAIL timeout_ack_priority: got rsp %0d err %b dat %h expected rsp 1 err 0 dat %h",
                     o.rv_cnt, o.err, o.dat, model_rsp_dat);
        end
`else
        run_txn(1'b0, 28'h0000500, 32'h0, 4'hF, 0, 100000, 1'b0, 1'b0, 32'h0, -1, 120, o);
        n_checks++;
        if (o.cyc_cnt !== 120 || o.rv_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL no_timeout_hold: got cyc %0d rsp %0d expected cyc 120 rsp 0", o.cyc_cnt, o.rv_cnt);
        end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 28'h0000700;
        req_dat   = $urandom;
        req_sel   = 4'hF;
        step();
        req_valid   = 1'b0;
        wbm_stall_i = 1'b0;
        step();
        n_checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_wait_entry: got cyc %b stb %b expected 1 0", wbm_cyc_o, wbm_stb_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_async: got cyc %b stb %b rsp_valid %b expected 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid);
        end
        step();
        rst = 1'b0;
        model_rsp_dat = '0;
        for (int i = 0; i < 3; i++) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = $urandom;
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rst_late_ack: got rsp_valid %b cyc %b expected 0 0", rsp_valid, wbm_cyc_o);
            end
        end
        wbm_ack_i = 1'b0;
        n_checks++;
        if (rsp_dat !== model_rsp_dat || req_ready !== 1'b1 || wbm_adr_o !== 28'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_after: got dat %h ready %b adr %h expected dat %h ready 1 adr 0",
                     rsp_dat, req_ready, wbm_adr_o, model_rsp_dat);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        step();
        test_reset();
        test_write_no_stall();
        test_read_stall();
        test_err_priority();
        test_busy_request();
        test_idle_ack();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wbm_bridge.md
WBM_BRIDGE -- requirements
Module: wbm_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: bus cycles allowed from request issue to ack/err before abort.
REQ-002 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 req_valid  in  1  request strobe from local CPU-side register logic.
REQ-005 req_ready  out  1  high when idle; request accepted when req_valid && req_ready.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_adr  in  28  word address.
REQ-008 req_dat  in  32  write data.
REQ-009 req_sel  in  4  byte lanes.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_dat  out  32  read data, held until next completion.
REQ-012 rsp_err  out  1  completion status: 1 = bus error or timeout; held with rsp_dat.
REQ-013 wbm_adr_o/wbm_dat_o/wbm_sel_o/wbm_we_o  out  28/32/4/1  pipelined Wishbone master request fields.
REQ-014 wbm_cyc_o/wbm_stb_o  out  1/1  Wishbone cycle and strobe.
REQ-015 wbm_dat_i/wbm_ack_i/wbm_err_i/wbm_stall_i  in  32/1/1/1  Wishbone response and stall.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT.
- IDLE: req_ready=1, cyc=stb=0.
- Accept -> REQ.
REQ-017 On accept, the block SHALL register adr/dat/sel/we into the wbm_*_o outputs and assert cyc=stb on the next cycle, which gives 1-cycle issue latency.
REQ-018 In REQ, stb SHALL stay high with stable fields while wbm_stall_i=1; on a cycle with stall=0, stb SHALL deassert next cycle and the FSM SHALL go to WAIT.
REQ-019 In REQ or WAIT, ack_i or err_i SHALL complete the transaction. This includes ack in the same cycle stall=0 is seen. On completion:
- cyc and stb drop the next cycle;
- rsp_valid pulses that cycle;
- FSM returns to IDLE.
REQ-020 On completion by ack, rsp_dat SHALL capture wbm_dat_i (reads only; writes leave rsp_dat unchanged) and rsp_err SHALL be 0.
REQ-021 If ack_i and err_i are asserted in the same cycle, err SHALL win: rsp_err=1 and rsp_dat unchanged.
REQ-022 Back-to-back: req_ready SHALL rise the cycle after rsp_valid, so throughput is at most one transaction per 3 cycles.
REQ-023 req_valid while busy SHALL be ignored and not queued.
REQ-024 ack_i/err_i while IDLE SHALL be ignored with no rsp_valid.
REQ-025 At most one transaction SHALL be outstanding; cyc SHALL never drop while stb=1 except on reset or timeout.

Reset
REQ-026 While rst=1 the block SHALL immediately force, asynchronously:
- cyc=stb=we=0, adr/dat/sel=0;
- rsp_valid=0, rsp_dat=0, rsp_err=0;
- state IDLE; req_ready=1 after release.
REQ-027 Reset mid-transaction SHALL abort without producing rsp_valid; a late ack after release SHALL be ignored per REQ-024.

Configuration
REQ-028 With macro WBM_BRIDGE_TIMEOUT_EN defined, a timeout counter SHALL be active:
- it counts cycles in REQ/WAIT and clears on accept;
- at count == TIMEOUT_CYCLES-1 with no ack/err, it drops cyc/stb next cycle and pulses rsp_valid with rsp_err=1;
- ack/err in the expiry cycle takes priority over timeout.
REQ-029 Without WBM_BRIDGE_TIMEOUT_EN, there SHALL be no counter logic and the bridge SHALL wait indefinitely in REQ/WAIT.

Structure
REQ-030 Package wbm_bridge_pkg SHALL hold the state enum typedef (IDLE/REQ/WAIT) and the Wishbone width localparams (ADR 28, DAT 32, SEL 4).
REQ-031 The timeout counter SHALL be sub-module wbm_timeout_ctr (inputs clear/enable, output expired), instantiated only under WBM_BRIDGE_TIMEOUT_EN.

Verification
REQ-032 Write with no stall: write 0x0000100 with data 0xDEADBEEF, sel 0xF; slave acks the cycle after stb -> one stb cycle with correct fields, rsp_valid once, rsp_err=0.
REQ-033 Read with stall: read 0x0000200; stall=1 for 3 cycles; ack with data 0x12345678 two cycles later -> stb held 4 cycles with stable adr, rsp_dat=0x12345678.
REQ-034 Error priority: slave asserts ack and err together -> rsp_err=1 and rsp_dat retains its previous value.
REQ-035 Timeout with TIMEOUT_CYCLES=16 and macro defined: slave never acks -> cyc drops and rsp_err=1 exactly 16 cycles after stb rose; without the macro, cyc stays high for 100+ cycles.
REQ-036 Reset mid-WAIT: assert rst in WAIT -> cyc=0 in the same cycle, no rsp_valid; ack after release is ignored.
REQ-037 Busy request: second req_valid during WAIT -> ignored; only one bus transaction is seen.
